// File: rtl/gpr_file_param_if.sv
// Decode/writeback-facing bus of the GPR file: two read ports, one write port, busy flag.
interface gpr_file_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] a1;
   logic [ADDR_W-1:0] a2;
   logic [ADDR_W-1:0] a3;
   logic              gpr_we;
   logic [DATA_W-1:0] wd;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              busy;

   modport master (
      output a1, a2, a3, gpr_we, wd,
      input  rd1, rd2, busy
   );

   modport slave (
      input  a1, a2, a3, gpr_we, wd,
      output rd1, rd2, busy
   );
endinterface

// File: rtl/gpr_file_param.sv
// Parametrised 2R/1W register file with hardwired zero register and a sequenced clear after reset.
// Optional macro GPR_BYPASS_EN forwards the same-cycle write data onto matching read ports.
module gpr_file_param #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   gpr_file_param_if.slave gpr
);
   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              busy_q, busy_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [DATA_W-1:0] rd1_val;
   logic [DATA_W-1:0] rd2_val;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         busy_q    <= busy_d;
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      busy_d    = busy_q;
      mem_we    = 1'b0;
      mem_waddr = gpr.a3;
      mem_wdata = gpr.wd;
      case (state_q)
         CLEAR: begin
            // The sweep owns the write port; user writes are dropped.
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == CLR_LAST) begin
               state_d = READY;
               busy_d  = 1'b0;
            end
         end
         READY: begin
            mem_we = gpr.gpr_we && (gpr.a3 != '0);
            busy_d = 1'b0;
         end
         default: begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
            busy_d    = 1'b1;
         end
      endcase
   end

   // NOTE: the array has no reset branch; the post-reset sweep zeroes it, so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (!reset && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      rd1_val = mem_q[gpr.a1];
      rd2_val = mem_q[gpr.a2];
`ifdef GPR_BYPASS_EN
      if (gpr.gpr_we && (gpr.a3 != '0) && (gpr.a1 == gpr.a3)) rd1_val = gpr.wd;
      if (gpr.gpr_we && (gpr.a3 != '0) && (gpr.a2 == gpr.a3)) rd2_val = gpr.wd;
`else
      // Without bypass the writeback-to-decode hazard is left to pipeline forwarding or stalls.
`endif
      if ((gpr.a1 == '0) || (state_q != READY)) rd1_val = '0;
      if ((gpr.a2 == '0) || (state_q != READY)) rd2_val = '0;
   end

   assign gpr.rd1  = rd1_val;
   assign gpr.rd2  = rd2_val;
   assign gpr.busy = busy_q;

endmodule

// File: tb/tb_gpr_file_param.sv
// Scoreboard bench for gpr_file_param: a 32x32 instance and a 16-bit, 8-entry instance.
module tb_gpr_file_param;
   logic clk;
   logic reset;
   logic reset_s;

   gpr_file_param_if #(.DATA_W(32), .ADDR_W(5)) ifc ();
   gpr_file_param_if #(.DATA_W(16), .ADDR_W(3)) ifs ();

   gpr_file_param #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .gpr   (ifc)
   );

   gpr_file_param #(.DATA_W(16), .ADDR_W(3)) dut_s (
      .clk   (clk),
      .reset (reset_s),
      .gpr   (ifs)
   );

   typedef struct {
      string       tag;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        busy;
   } rec_t;

   rec_t        exp_q[$];
   rec_t        obs_q[$];
   logic [31:0] model   [32];
   logic [31:0] model_s [8];
   int          checks = 0;
   int          errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference read of the wide instance in READY, including same-cycle bypass when built with it.
   function automatic logic [31:0] exp_read(input int addr, input logic we, input int a3,
                                            input logic [31:0] wd);
      if (addr == 0) return 32'h0;
`ifdef GPR_BYPASS_EN
      if (we && (a3 != 0) && (addr == a3)) return wd;
`endif
      return model[addr];
   endfunction

   task automatic sample(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                         input logic eb);
      rec_t e, o;
      e = '{tag, e1, e2, eb};
      exp_q.push_back(e);
      #1;
      o = '{tag, ifc.rd1, ifc.rd2, ifc.busy};
      obs_q.push_back(o);
   endtask

   task automatic sample_s(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input logic eb);
      rec_t e, o;
      e = '{tag, e1, e2, eb};
      exp_q.push_back(e);
      #1;
      o = '{tag, {16'h0, ifs.rd1}, {16'h0, ifs.rd2}, ifs.busy};
      obs_q.push_back(o);
   endtask

   task automatic write_reg(input int addr, input logic [31:0] data);
      @(negedge clk);
      ifc.a3     = 5'(addr);
      ifc.wd     = data;
      ifc.gpr_we = 1'b1;
      @(negedge clk);
      ifc.gpr_we = 1'b0;
      if (addr != 0) model[addr] = data;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // Counts negedges after reset release until busy drops; -1 if it never does.
   task automatic wait_sweep(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (ifc.busy === 1'b0) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      rec_t e, o;
      @(negedge clk);
      ifc.a1 = 5'd5;
      ifc.a2 = 5'd0;
      sample("reset_hold", 32'h0, 32'h0, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_model();
      wait_sweep(n);
      checks++;
      if (n !== 32) begin
         errors++;
         $display("FAIL sweep_len: busy edges after release=%0d, want 32", n);
      end
      for (int i = 0; i < 32; i++) begin
         ifc.a1 = 5'(i);
         ifc.a2 = 5'(31 - i);
         sample("sweep_zero", 32'h0, 32'h0, 1'b0);
         @(negedge clk);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.rd1 !== e.rd1 || o.rd2 !== e.rd2 || o.busy !== e.busy) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h busy=%b, want rd1=%h rd2=%h busy=%b",
                     e.tag, o.rd1, o.rd2, o.busy, e.rd1, e.rd2, e.busy);
         end
      end
   endtask

   task automatic test_write_read();
      int addrs[6];
      rec_t e, o;
      write_reg(5, 32'hDEADBEEF);
      ifc.a1 = 5'd5;
      ifc.a2 = 5'd5;
      sample("wr_5", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      write_reg(0, 32'h12345678);
      ifc.a1 = 5'd0;
      ifc.a2 = 5'd5;
      sample("wr_zero", 32'h0, 32'hDEADBEEF, 1'b0);
      for (int i = 0; i < 6; i++) begin
         addrs[i] = int'($urandom_range(31, 1));
         write_reg(addrs[i], $urandom());
      end
      for (int i = 0; i < 6; i++) begin
         int b;
         b = int'($urandom_range(31, 0));
         ifc.a1 = 5'(addrs[i]);
         ifc.a2 = 5'(b);
         sample("wr_rand", exp_read(addrs[i], 1'b0, 0, 32'h0), exp_read(b, 1'b0, 0, 32'h0), 1'b0);
         @(negedge clk);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.rd1 !== e.rd1 || o.rd2 !== e.rd2 || o.busy !== e.busy) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h busy=%b, want rd1=%h rd2=%h busy=%b",
                     e.tag, o.rd1, o.rd2, o.busy, e.rd1, e.rd2, e.busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      int prev = 0;
      rec_t e, o;
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         int          wa;
         logic [31:0] wdat;
         wa   = (k == 5) ? 0 : int'($urandom_range(31, 1));
         wdat = $urandom();
         ifc.a3     = 5'(wa);
         ifc.wd     = wdat;
         ifc.gpr_we = 1'b1;
         ifc.a1     = 5'(prev);
         ifc.a2     = 5'(wa);
         sample("b2b", exp_read(prev, 1'b1, wa, wdat), exp_read(wa, 1'b1, wa, wdat), 1'b0);
         if (wa != 0) model[wa] = wdat;
         prev = wa;
         @(negedge clk);
      end
      ifc.gpr_we = 1'b0;
      ifc.a1     = 5'(prev);
      ifc.a2     = 5'd0;
      sample("b2b_last", exp_read(prev, 1'b0, 0, 32'h0), 32'h0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.rd1 !== e.rd1 || o.rd2 !== e.rd2 || o.busy !== e.busy) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h busy=%b, want rd1=%h rd2=%h busy=%b",
                     e.tag, o.rd1, o.rd2, o.busy, e.rd1, e.rd2, e.busy);
         end
      end
   endtask

   task automatic test_same_cycle();
      rec_t e, o;
      write_reg(7, 32'h11);
      ifc.a3     = 5'd7;
      ifc.wd     = 32'h55;
      ifc.gpr_we = 1'b1;
      ifc.a1     = 5'd7;
      ifc.a2     = 5'd7;
      sample("rw_same_pre", exp_read(7, 1'b1, 7, 32'h55), exp_read(7, 1'b1, 7, 32'h55), 1'b0);
      model[7] = 32'h55;
      @(negedge clk);
      ifc.gpr_we = 1'b0;
      sample("rw_same_post", 32'h55, 32'h55, 1'b0);
      @(negedge clk);
      ifc.a3     = 5'd0;
      ifc.wd     = 32'hFFFF_FFFF;
      ifc.gpr_we = 1'b1;
      ifc.a1     = 5'd0;
      ifc.a2     = 5'd7;
      sample("rw_zero", 32'h0, 32'h55, 1'b0);
      @(negedge clk);
      ifc.gpr_we = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.rd1 !== e.rd1 || o.rd2 !== e.rd2 || o.busy !== e.busy) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h busy=%b, want rd1=%h rd2=%h busy=%b",
                     e.tag, o.rd1, o.rd2, o.busy, e.rd1, e.rd2, e.busy);
         end
      end
   endtask

   task automatic test_write_during_sweep();
      int n;
      rec_t e, o;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      clear_model();
      // Early writes target 31, late ones target 3 after the sweep has already passed it.
      for (int i = 0; i < 31; i++) begin
         ifc.a3     = (i < 5) ? 5'd31 : 5'd3;
         ifc.wd     = 32'hFFFF_FFFF;
         ifc.gpr_we = 1'b1;
         ifc.a1     = ifc.a3;
         ifc.a2     = 5'(i);
         sample("sweep_wr", 32'h0, 32'h0, 1'b1);
         @(negedge clk);
      end
      ifc.gpr_we = 1'b0;
      wait_sweep(n);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL sweep_wr_len: extra edges after 31=%0d, want 1", n);
      end
      ifc.a1 = 5'd31;
      ifc.a2 = 5'd3;
      sample("sweep_wr_after", 32'h0, 32'h0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.rd1 !== e.rd1 || o.rd2 !== e.rd2 || o.busy !== e.busy) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h busy=%b, want rd1=%h rd2=%h busy=%b",
                     e.tag, o.rd1, o.rd2, o.busy, e.rd1, e.rd2, e.busy);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      rec_t e, o;
      write_reg(1, 32'hA5A5A5A5);
      write_reg(2, 32'hA5A5A5A5);
      write_reg(17, 32'hA5A5A5A5);
      write_reg(31, 32'hA5A5A5A5);
      ifc.a1 = 5'd17;
      ifc.a2 = 5'd31;
      sample("mid_pre", 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sample("mid_sweep", 32'h0, 32'h0, 1'b1);
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      clear_model();
      wait_sweep(n);
      checks++;
      if (n !== 32) begin
         errors++;
         $display("FAIL mid_restart_len: busy edges after re-release=%0d, want 32", n);
      end
      for (int i = 0; i < 32; i++) begin
         ifc.a1 = 5'(i);
         ifc.a2 = 5'(i ^ 16);
         sample("mid_zero", 32'h0, 32'h0, 1'b0);
         @(negedge clk);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.rd1 !== e.rd1 || o.rd2 !== e.rd2 || o.busy !== e.busy) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h busy=%b, want rd1=%h rd2=%h busy=%b",
                     e.tag, o.rd1, o.rd2, o.busy, e.rd1, e.rd2, e.busy);
         end
      end
   endtask

   task automatic test_param_small();
      int n;
      rec_t e, o;
      @(negedge clk);
      reset_s = 1'b1;
      @(negedge clk);
      reset_s = 1'b0;
      for (int i = 0; i < 8; i++) model_s[i] = 32'h0;
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (ifs.busy === 1'b0) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL small_sweep_len: busy edges after release=%0d, want 8", n);
      end
      for (int i = 0; i < 8; i++) begin
         ifs.a1 = 3'(i);
         ifs.a2 = 3'(7 - i);
         sample_s("small_zero", model_s[i], model_s[7 - i], 1'b0);
         @(negedge clk);
      end
      ifs.a3     = 3'd7;
      ifs.wd     = 16'hBEEF;
      ifs.gpr_we = 1'b1;
      @(negedge clk);
      model_s[7] = 32'h0000_BEEF;
      ifs.a3     = 3'd0;
      ifs.wd     = 16'h1234;
      ifs.a1     = 3'd7;
      ifs.a2     = 3'd7;
      sample_s("small_r7", model_s[7], model_s[7], 1'b0);
      @(negedge clk);
      ifs.a3 = 3'd3;
      ifs.wd = 16'hFFFF;
      @(negedge clk);
      model_s[3] = 32'h0000_FFFF;
      ifs.gpr_we = 1'b0;
      ifs.a1     = 3'd0;
      ifs.a2     = 3'd3;
      sample_s("small_r0_r3", 32'h0, model_s[3], 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         checks++;
         if (o.rd1 !== e.rd1 || o.rd2 !== e.rd2 || o.busy !== e.busy) begin
            errors++;
            $display("FAIL %s: got rd1=%h rd2=%h busy=%b, want rd1=%h rd2=%h busy=%b",
                     e.tag, o.rd1, o.rd2, o.busy, e.rd1, e.rd2, e.busy);
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      reset_s    = 1'b1;
      ifc.a1     = '0;
      ifc.a2     = '0;
      ifc.a3     = '0;
      ifc.gpr_we = 1'b0;
      ifc.wd     = '0;
      ifs.a1     = '0;
      ifs.a2     = '0;
      ifs.a3     = '0;
      ifs.gpr_we = 1'b0;
      ifs.wd     = '0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_same_cycle();
      test_write_during_sweep();
      test_reset_mid_sweep();
      test_param_small();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
